// File: rtl/uart_rx_module.sv
// UART receiver: 2-flop synced input, mid-bit sampling, 8N1 frames.
// Define UART_RX_PARITY_EN to add an even-parity bit and RX_Parity_Err.
module uart_rx_module #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic       RX_Done_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Frame_Err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       RX_Parity_Err
`endif
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             done_n, ferr_n;
    logic             sync1, sync2, hist;
    logic             fall;
`ifdef UART_RX_PARITY_EN
    logic             par, par_n;
    logic             perr_n;
`endif

    assign fall = hist & ~sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            hist         <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            RX_Data      <= '0;
            RX_Done_Sig  <= 1'b0;
            RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par           <= 1'b0;
            RX_Parity_Err <= 1'b0;
`endif
        end else begin
            sync1        <= RX_Pin_In;
            sync2        <= sync1;
            hist         <= sync2;
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shift        <= shift_n;
            RX_Data      <= data_n;
            RX_Done_Sig  <= done_n;
            RX_Frame_Err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par           <= par_n;
            RX_Parity_Err <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + ONE;
        idx_n   = idx;
        shift_n = shift;
        data_n  = RX_Data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
        perr_n  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall && RX_En_Sig)
                    state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    idx_n   = '0;
                    state_n = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n          = '0;
                    shift_n[idx]   = sync2;
                    idx_n          = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL) begin
                    par_n   = sync2;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL) begin
                    // a low stop bit outranks any parity problem
                    if (!sync2) begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift, par}) begin
                        perr_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        data_n  = shift;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (sync2)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state)
            cnt_n = '0;
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// Scoreboard bench for uart_rx_module at 16 clocks per bit.
// Expected Done/Err events are queued by the sender and matched on output.
module tb_uart_rx_module;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic       RX_En_Sig = 1'b1;
    logic       RX_Done_Sig;
    logic [7:0] RX_Data;
    logic       RX_Frame_Err;
`ifdef UART_RX_PARITY_EN
    logic       RX_Parity_Err;
`else
    logic       RX_Parity_Err = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   t_fall = 0;

    uart_rx_module #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_Pin_In    (RX_Pin_In),
        .RX_En_Sig    (RX_En_Sig),
        .RX_Done_Sig  (RX_Done_Sig),
        .RX_Data      (RX_Data),
        .RX_Frame_Err (RX_Frame_Err)
`ifdef UART_RX_PARITY_EN
        ,
        .RX_Parity_Err(RX_Parity_Err)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    // kind: 0 done, 1 frame error, 2 parity error
    always @(negedge CLK) begin
        if (!RST && (RX_Done_Sig || RX_Frame_Err || RX_Parity_Err)) begin
            int   k;
            exp_t e;
            k = RX_Done_Sig ? 0 : (RX_Frame_Err ? 1 : 2);
            check("pulse_excl",
                  int'(RX_Done_Sig) + int'(RX_Frame_Err) + int'(RX_Parity_Err), 1);
            if (sb.size() == 0) begin
                check("spurious_pulse_kind", k, -1);
            end else begin
                e = sb.pop_front();
                check("event_kind", k, e.kind);
                check("rx_data", int'(RX_Data), int'(e.data));
                if (e.lat) begin
                    int l;
                    l = cyc - t_fall;
                    check("latency", (l >= 153 && l <= 155) ? 154 : l, 154);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b, input bit stop, input int rst_bit,
                        input int en_bit, input bit bad_par);
        logic [10:0] bits;
        int          nb;
`ifdef UART_RX_PARITY_EN
        bits = {stop, (^b) ^ bad_par, b, 1'b0};
        nb = 11;
`else
        bits = {1'b0, stop, b, 1'b0};
        nb = 10;
`endif
        t_fall = cyc;
        for (int i = 0; i < nb; i++) begin
            RX_Pin_In = bits[i];
            for (int c = 0; c < CPB; c++) begin
                if (c == 0 && i == rst_bit + 1) RST = 1'b1;
                if (c == 1) RST = 1'b0;
                if (c == 0 && i == en_bit + 1) RX_En_Sig = 1'b0;
                @(negedge CLK);
            end
        end
        RX_Pin_In = 1'b1;
    endtask

    task automatic expect_ev(input int k, input logic [7:0] d, input bit lat);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    initial begin
        int w;
        idle(4);
        check("rst_done", int'(RX_Done_Sig), 0);
        check("rst_data", int'(RX_Data), 0);
        check("rst_ferr", int'(RX_Frame_Err), 0);
        RST = 1'b0;
        idle(10);

        expect_ev(0, 8'hA5, 1'b1);
        send(8'hA5, 1'b1, -9, -9, 1'b0);
        idle(30);

        RX_Pin_In = 1'b0;
        idle(4);
        RX_Pin_In = 1'b1;
        idle(40);
        expect_ev(0, 8'h3C, 1'b0);
        send(8'h3C, 1'b1, -9, -9, 1'b0);
        idle(30);

        expect_ev(0, 8'h11, 1'b0);
        send(8'h11, 1'b1, -9, -9, 1'b0);
        idle(20);
        expect_ev(1, 8'h11, 1'b0);
        send(8'h5A, 1'b0, -9, -9, 1'b0);
        RX_Pin_In = 1'b0;
        idle(40);
        RX_Pin_In = 1'b1;
        idle(20);
        check("data_after_ferr", int'(RX_Data), 8'h11);
        expect_ev(0, 8'h22, 1'b0);
        send(8'h22, 1'b1, -9, -9, 1'b0);
        idle(30);

        RX_En_Sig = 1'b0;
        send(8'h77, 1'b1, -9, -9, 1'b0);
        idle(30);
        RX_En_Sig = 1'b1;
        idle(5);
        expect_ev(0, 8'h88, 1'b0);
        send(8'h88, 1'b1, -9, 3, 1'b0);
        idle(30);
        RX_En_Sig = 1'b1;
        idle(5);

        send(8'hF0, 1'b1, 4, -9, 1'b0);
        idle(30);
        check("data_after_rst", int'(RX_Data), 0);
        expect_ev(0, 8'h0F, 1'b0);
        send(8'h0F, 1'b1, -9, -9, 1'b0);
        idle(30);

        expect_ev(0, 8'h00, 1'b0);
        expect_ev(0, 8'hFF, 1'b0);
        send(8'h00, 1'b1, -9, -9, 1'b0);
        send(8'hFF, 1'b1, -9, -9, 1'b0);
        idle(30);

`ifdef UART_RX_PARITY_EN
        expect_ev(2, 8'hFF, 1'b0);
        send(8'hFF, 1'b1, -9, -9, 1'b1);
        idle(30);
`endif

        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge CLK);
            w++;
        end
        check("sb_empty", sb.size(), 0);
        check("final_data", int'(RX_Data), 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
- Bit-level UART receiver for the serial input pin.
- Detects the start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit.
- Presents the byte on RX_Data with a 1-cycle RX_Done_Sig pulse.
- Sits directly upstream of the receive control stage, which latches RX_Data on RX_Done_Sig and drives RX_En_Sig back to gate reception.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 8..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_Pin_In  input  1  asynchronous serial line, idle high.
- RX_En_Sig  input  1  receive enable; new frames are accepted only while high.
- RX_Done_Sig  output  1  1-cycle pulse when a valid frame completes.
- RX_Data  output  8  last valid received byte; held until the next valid frame.
- RX_Frame_Err  output  1  1-cycle pulse when the stop bit samples low.

Interface decision (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset values (RST high at a CLK edge):
  - State IDLE, baud counter 0, bit index 0, shift register 0.
  - Synchronizer flops 1, so no false edge is seen after reset.
  - Outputs: RX_Done_Sig 0, RX_Data 8'h00, RX_Frame_Err 0.
- Input path: RX_Pin_In passes through a 2-flop synchronizer plus one history flop. A falling edge is history=1 and synced=0.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change. "Half point" = CLKS_PER_BIT/2 - 1, integer division. "Full point" = CLKS_PER_BIT - 1.
- IDLE:
  - On a falling edge with RX_En_Sig=1 -> START, counter cleared.
  - Falling edges with RX_En_Sig=0 are ignored.
- START: at the half point, resample the synced line.
  - Line 0 -> DATA, bit index 0.
  - Line 1 -> treat as a glitch, return to IDLE with no output activity.
- DATA:
  - At each full point, shift the synced line into bit[index], LSB first.
  - After index 7 -> STOP.
- STOP: at the full point, sample the line.
  - Line 1: RX_Data <= shift register and RX_Done_Sig=1 in the same cycle, then -> IDLE.
  - Line 0: RX_Frame_Err=1 for 1 cycle, RX_Data unchanged, no RX_Done_Sig, then -> BREAK.
- BREAK: wait until the synced line is 1, then -> IDLE. Prevents a held-low line (break) from retriggering.
- RX_En_Sig dropping mid-frame does not abort the frame; the frame completes normally. RX_En_Sig is checked only in IDLE.
- A falling edge arriving in the same cycle as STOP->IDLE is missed; the next frame must start at least 1 cycle after the stop-bit sample. A standard 1-stop-bit sender is therefore supported.
- Latency: RX_Done_Sig asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after RX_Pin_In falls.
- RST asserted mid-frame: immediate return to reset values. The partial byte is discarded and no Done or Err pulse occurs.
- RX_Done_Sig and RX_Frame_Err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP. It samples one even-parity bit at its full point.
  - Adds output port RX_Parity_Err (1 bit, reset 0). It pulses for 1 cycle in the STOP-sample cycle when XOR(data bits, parity bit) = 1.
  - On a parity error, RX_Data is not updated and RX_Done_Sig is suppressed.
  - A frame error takes priority: only RX_Frame_Err pulses if both errors occur.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state, no RX_Parity_Err port, 10-bit frame.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Send 0xA5 with RX_En_Sig=1 -> exactly one RX_Done_Sig pulse at about 154 cycles after the pin falls; RX_Data=8'hA5; RX_Frame_Err stays 0.
- Pulse the pin low for 4 cycles, then high -> START rejects it as a glitch; no Done, no Err; the next frame 0x3C is received correctly.
- Send 0x5A with stop bit = 0, preceded by a valid 0x11 -> RX_Frame_Err pulses once, RX_Data stays 8'h11; the line is held low 40 cycles with no retrigger; the following 0x22 is received correctly.
- RX_En_Sig=0 during the start edge of 0x77 -> no Done. Then enable RX_En_Sig and drop it during bit 3 of 0x88 -> Done with RX_Data=8'h88.
- Assert RST for 1 cycle during bit 4 of 0xF0 -> no Done, RX_Data=8'h00; the next 0x0F is received correctly.
- Back-to-back 0x00 then 0xFF, 1-stop-bit spacing -> two Done pulses with RX_Data 8'h00 then 8'hFF. With UART_RX_PARITY_EN defined, repeat 0xFF with parity bit 1 -> RX_Parity_Err pulses, no Done.
